// File: rtl/vga_scan_out_if.sv
// Frame-buffer read port between vga_scan_out (master) and the output
// frame buffer mem1 (slave). The address leads, and the data returns
// a fixed number of clocks later.
interface vga_scan_out_if;
  logic [18:0] addr;
  logic [3:0]  din;

  modport master (output addr, input din);
  modport slave  (input addr, output din);
endinterface

// File: rtl/vga_scan_out.sv
// vga_scan_out: reads the 4-bit Sobel edge image out of the frame buffer
// and drives a VGA monitor with grayscale RGB and active-low syncs.
//
// The pipeline is counter stage -> address register -> RD_LAT clocks of
// buffer read -> output register. The sync, visible, state and frame flags
// ride a matching delay line, so every output pin refers to the same pixel.
//
// Optional feature: define VGA_BORDER_EN to paint the outermost visible
// rows and columns 4'hF while showing. These are the pixels that core
// leaves unfiltered.
module vga_scan_out #(
  parameter int width  = 640,
  parameter int height = 480,
  parameter int hFront = 16,
  parameter int hSync  = 96,
  parameter int hBack  = 48,
  parameter int vFront = 10,
  parameter int vSync  = 2,
  parameter int vBack  = 33,
  parameter int RD_LAT = 1    // legal range 1..4
) (
  input  logic                  clk24,
  input  logic                  rst_n,
  input  logic                  en,
  vga_scan_out_if.master        fb,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic                  active
);

  localparam int HT = width + hFront + hSync + hBack;
  localparam int VT = height + vFront + vSync + vBack;
  // Depth of the flag delay line that feeds the output register.
  localparam int DL = RD_LAT + 1;

  localparam logic [9:0]  H_LAST   = 10'(HT - 1);
  localparam logic [9:0]  V_LAST   = 10'(VT - 1);
  localparam logic [9:0]  H_VIS    = 10'(width);
  localparam logic [9:0]  V_VIS    = 10'(height);
  localparam logic [9:0]  H_RIGHT  = 10'(width - 1);
  localparam logic [9:0]  V_BOTTOM = 10'(height - 1);
  localparam logic [9:0]  HS_FIRST = 10'(width + hFront);
  localparam logic [9:0]  HS_LAST  = 10'(width + hFront + hSync - 1);
  localparam logic [9:0]  VS_FIRST = 10'(height + vFront);
  localparam logic [9:0]  VS_LAST  = 10'(height + vFront + vSync - 1);
  localparam logic [18:0] LINE_W   = 19'(width);

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t     state;
  logic [9:0] hcnt;
  logic [9:0] vcnt;

  logic       visible_c;
  logic       hsync_c;
  logic       vsync_c;
  logic       origin_c;
  logic       show_c;
  logic [3:0] pix;

  logic [DL-1:0] hs_d;
  logic [DL-1:0] vs_d;
  logic [DL-1:0] vis_d;
  logic [DL-1:0] show_d;
  logic [DL-1:0] fs_d;
`ifdef VGA_BORDER_EN
  logic          border_c;
  logic [DL-1:0] bd_d;
`endif

  // Free-running raster position: hcnt sweeps a line and vcnt steps on each wrap.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Counter-stage decode. At the frame origin, the state that applies to this frame is the one being chosen from en right now.
  always_comb begin
    visible_c = (hcnt < H_VIS) && (vcnt < V_VIS);
    hsync_c   = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    vsync_c   = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    origin_c  = (hcnt == 10'd0) && (vcnt == 10'd0);
    show_c    = origin_c ? en : (state == SHOW);
`ifdef VGA_BORDER_EN
    border_c  = (hcnt == 10'd0) || (hcnt == H_RIGHT) ||
                (vcnt == 10'd0) || (vcnt == V_BOTTOM);
`endif
  end

  // Display state only changes at the frame origin, so frames are never cut short.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
    end else if (origin_c) begin
      state <= en ? SHOW : BLANK;
    end
  end

  // Linear buffer address for each visible pixel; it holds during blanking.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      fb.addr <= '0;
    end else if (visible_c) begin
      fb.addr <= 19'(vcnt) * LINE_W + 19'(hcnt);
    end
  end

  // Flag delay line covering the address register plus the buffer read latency.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      hs_d   <= '1;
      vs_d   <= '1;
      vis_d  <= '0;
      show_d <= '0;
      fs_d   <= '0;
`ifdef VGA_BORDER_EN
      bd_d   <= '0;
`endif
    end else begin
      hs_d   <= {hs_d[DL-2:0],   hsync_c};
      vs_d   <= {vs_d[DL-2:0],   vsync_c};
      vis_d  <= {vis_d[DL-2:0],  visible_c};
      show_d <= {show_d[DL-2:0], show_c};
      fs_d   <= {fs_d[DL-2:0],   origin_c};
`ifdef VGA_BORDER_EN
      bd_d   <= {bd_d[DL-2:0],   border_c};
`endif
    end
  end

  // Pixel value for the output register: returned data when showing a visible pixel, black otherwise.
  always_comb begin
    pix = 4'h0;
    if (vis_d[DL-1] && show_d[DL-1]) begin
`ifdef VGA_BORDER_EN
      pix = bd_d[DL-1] ? 4'hF : fb.din;
`else
      pix = fb.din;
`endif
    end
  end

  // Output register: all pins update together, one clock after the data returns.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      active      <= 1'b0;
    end else begin
      vga_r       <= pix;
      vga_g       <= pix;
      vga_b       <= pix;
      hsync       <= hs_d[DL-1];
      vsync       <= vs_d[DL-1];
      frame_start <= fs_d[DL-1];
      active      <= show_d[DL-1];
    end
  end

endmodule
